// File: rtl/controlador_comandos.sv
// Two-byte UART command controller: decodes command/address, queries a sensor, answers with a code byte and a data byte.
// Optional response timeout is built when CONTROLADOR_TIMEOUT_EN is defined.
module controlador_comandos #(
  parameter int NUM_SENSORES   = 32,
  parameter int CICLOS_TIMEOUT = 2500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bitsEstaoRecebidos,
  input  logic [7:0] primeiroByteCompleto,
  input  logic [7:0] segundoByteCompleto,
  output logic       sensorSolicita,
  output logic [2:0] sensorComando,
  output logic [4:0] sensorEndereco,
  input  logic       sensorPronto,
  input  logic [7:0] sensorDado,
  output logic       txInicio,
  output logic [7:0] txByte,
  input  logic       txConcluido,
  output logic       ocupado
);

  if (NUM_SENSORES < 1 || NUM_SENSORES > 32) begin : g_num_sensores_invalido
    $error("NUM_SENSORES must lie in 1..32");
  end
  if (CICLOS_TIMEOUT < 1 || CICLOS_TIMEOUT > 4194304) begin : g_ciclos_timeout_invalido
    $error("CICLOS_TIMEOUT must fit in 22 bits");
  end

  typedef enum logic [3:0] {
    ESPERA, AGUARDA_SEGUNDO, DECODIFICA, SOLICITA, AGUARDA_SENSOR,
    ENVIA1, ESPERA_TX1, ENVIA2, ESPERA_TX2
  } estado_t;

  localparam logic [8:0] LIMITE_END = 9'(NUM_SENSORES);

  estado_t    estado_q, estado_d;
  logic [7:0] comando_q, comando_d;
  logic [7:0] endereco_q, endereco_d;
  logic [7:0] dado_q, dado_d;
  logic       solicita_q, solicita_d;
  logic [2:0] sens_cmd_q, sens_cmd_d;
  logic [4:0] sens_end_q, sens_end_d;
  logic       tx_inicio_q, tx_inicio_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       ocupado_q, ocupado_d;
`ifdef CONTROLADOR_TIMEOUT_EN
  localparam logic [21:0] ULTIMO = 22'(CICLOS_TIMEOUT - 1);
  logic [21:0] cnt_q, cnt_d;
`endif

  // The response code byte is loaded straight into tx_byte_q on entry to ENVIA1.
  always_comb begin
    estado_d    = estado_q;
    comando_d   = comando_q;
    endereco_d  = endereco_q;
    dado_d      = dado_q;
    solicita_d  = solicita_q;
    sens_cmd_d  = sens_cmd_q;
    sens_end_d  = sens_end_q;
    tx_inicio_d = 1'b0;
    tx_byte_d   = tx_byte_q;
`ifdef CONTROLADOR_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (estado_q)
      ESPERA: begin
        if (bitsEstaoRecebidos) begin
          estado_d = AGUARDA_SEGUNDO;
`ifdef CONTROLADOR_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      AGUARDA_SEGUNDO: begin
        if (bitsEstaoRecebidos) begin
          comando_d  = primeiroByteCompleto;
          endereco_d = segundoByteCompleto;
          estado_d   = DECODIFICA;
        end
`ifdef CONTROLADOR_TIMEOUT_EN
        else if (cnt_q == ULTIMO) estado_d = ESPERA;
        else cnt_d = cnt_q + 22'd1;
`endif
      end
      DECODIFICA: begin
        if (comando_q > 8'h07) begin
          tx_byte_d   = 8'hFF;
          dado_d      = comando_q;
          tx_inicio_d = 1'b1;
          estado_d    = ENVIA1;
        end else if ({1'b0, endereco_q} >= LIMITE_END) begin
          tx_byte_d   = 8'hFE;
          dado_d      = endereco_q;
          tx_inicio_d = 1'b1;
          estado_d    = ENVIA1;
        end else begin
          solicita_d = 1'b1;
          sens_cmd_d = comando_q[2:0];
          sens_end_d = endereco_q[4:0];
          estado_d   = SOLICITA;
        end
      end
      SOLICITA: begin
        estado_d = AGUARDA_SENSOR;
`ifdef CONTROLADOR_TIMEOUT_EN
        cnt_d    = '0;
`endif
      end
      AGUARDA_SENSOR: begin
        // Sensor data beats a timeout that expires on the same edge.
        if (sensorPronto) begin
          tx_byte_d   = {5'b10000, comando_q[2:0]};
          dado_d      = sensorDado;
          solicita_d  = 1'b0;
          tx_inicio_d = 1'b1;
          estado_d    = ENVIA1;
        end
`ifdef CONTROLADOR_TIMEOUT_EN
        else if (cnt_q == ULTIMO) begin
          tx_byte_d   = 8'hFD;
          dado_d      = endereco_q;
          solicita_d  = 1'b0;
          tx_inicio_d = 1'b1;
          estado_d    = ENVIA1;
        end else cnt_d = cnt_q + 22'd1;
`endif
      end
      ENVIA1: estado_d = ESPERA_TX1;
      ESPERA_TX1: begin
        if (txConcluido) begin
          tx_byte_d   = dado_q;
          tx_inicio_d = 1'b1;
          estado_d    = ENVIA2;
        end
      end
      ENVIA2: estado_d = ESPERA_TX2;
      ESPERA_TX2: if (txConcluido) estado_d = ESPERA;
      default: estado_d = ESPERA;
    endcase
    ocupado_d = (estado_d != ESPERA);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= ESPERA;
      comando_q   <= '0;
      endereco_q  <= '0;
      dado_q      <= '0;
      solicita_q  <= 1'b0;
      sens_cmd_q  <= '0;
      sens_end_q  <= '0;
      tx_inicio_q <= 1'b0;
      tx_byte_q   <= '0;
      ocupado_q   <= 1'b0;
`ifdef CONTROLADOR_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      estado_q    <= estado_d;
      comando_q   <= comando_d;
      endereco_q  <= endereco_d;
      dado_q      <= dado_d;
      solicita_q  <= solicita_d;
      sens_cmd_q  <= sens_cmd_d;
      sens_end_q  <= sens_end_d;
      tx_inicio_q <= tx_inicio_d;
      tx_byte_q   <= tx_byte_d;
      ocupado_q   <= ocupado_d;
`ifdef CONTROLADOR_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign sensorSolicita = solicita_q;
  assign sensorComando  = sens_cmd_q;
  assign sensorEndereco = sens_end_q;
  assign txInicio       = tx_inicio_q;
  assign txByte         = tx_byte_q;
  assign ocupado        = ocupado_q;

endmodule

// File: tb/tb_controlador_comandos.sv
// Randomized bench for controlador_comandos; the bench plays UART receiver, sensor and transmitter.
module tb_controlador_comandos;
  localparam int NS = 32;
  localparam int CT = 100;
`ifdef CONTROLADOR_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b0;
  logic [7:0] primeiro = 8'h00, segundo = 8'h00;
  logic       sensorSolicita;
  logic [2:0] sensorComando;
  logic [4:0] sensorEndereco;
  logic       pronto = 1'b0;
  logic [7:0] sdado = 8'h00;
  logic       txInicio;
  logic [7:0] txByte;
  logic       txc = 1'b0;
  logic       ocupado;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  controlador_comandos #(.NUM_SENSORES(NS), .CICLOS_TIMEOUT(CT)) dut (
    .clock(clock), .reset(reset),
    .bitsEstaoRecebidos(rx), .primeiroByteCompleto(primeiro), .segundoByteCompleto(segundo),
    .sensorSolicita(sensorSolicita), .sensorComando(sensorComando), .sensorEndereco(sensorEndereco),
    .sensorPronto(pronto), .sensorDado(sdado),
    .txInicio(txInicio), .txByte(txByte), .txConcluido(txc), .ocupado(ocupado)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_pair(input logic [7:0] cmd, input logic [7:0] addr, input int gap, input bit skip_first);
    if (!skip_first) begin
      primeiro = 8'($urandom); segundo = 8'($urandom); rx = 1'b1;
      @(negedge clock); rx = 1'b0;
      repeat (gap) @(negedge clock);
    end
    primeiro = cmd; segundo = addr; rx = 1'b1;
    @(negedge clock); rx = 1'b0;
  endtask

  // p: cycle (0 = first cycle with a request visible) at which the sensor answers, <0 for never.
  task automatic txn(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] dat,
                     input int p, input int extra_at, input int gap, input bit skip_first);
    logic [7:0] e0, e1;
    logic [7:0] got [2];
    bit sens;
    int cyc, ntx, done_at;
    sens = 1'b0;
    if (cmd > 8'd7) begin e0 = 8'hFF; e1 = cmd; end
    else if (int'(addr) >= NS) begin e0 = 8'hFE; e1 = addr; end
    else begin
      sens = 1'b1;
      if (TEN && (p < 0 || p > CT)) begin e0 = 8'hFD; e1 = addr; end
      else begin e0 = 8'h80 | (cmd & 8'h07); e1 = dat; end
    end
    got[0] = 8'h00; got[1] = 8'h00;
    send_pair(cmd, addr, gap, skip_first);
    check_eq("lat_quiet", {30'd0, sensorSolicita, txInicio}, 32'd0);
    @(negedge clock);
    if (sens) begin
      check_eq("lat_req", 32'(sensorSolicita), 32'd1);
      check_eq("req_cmd", 32'(sensorComando), 32'(cmd & 8'h07));
      check_eq("req_addr", 32'(sensorEndereco), 32'(addr & 8'h1F));
    end else begin
      check_eq("lat_tx", 32'(txInicio), 32'd1);
      check_eq("no_req", 32'(sensorSolicita), 32'd0);
    end
    cyc = 0; ntx = 0; done_at = -1;
    while (cyc < 400 && !(ntx == 2 && cyc > done_at)) begin
      if (txInicio) begin
        if (ntx < 2) got[ntx] = txByte;
        check_eq("req_low_tx", 32'(sensorSolicita), 32'd0);
        ntx++;
        done_at = cyc + 1 + int'($urandom_range(0, 3));
      end
      if (cyc == done_at && ntx <= 2) check_eq("tx_stable", 32'(txByte), 32'(got[ntx-1]));
      if (sens && cyc == p && !(TEN && p > CT)) check_eq("req_hold", 32'(sensorSolicita), 32'd1);
      pronto = (cyc == p);
      sdado  = (cyc == p) ? dat : 8'($urandom);
      txc    = (cyc == done_at);
      rx     = (cyc == extra_at);
      primeiro = 8'($urandom); segundo = 8'($urandom);
      @(negedge clock);
      cyc++;
    end
    pronto = 1'b0; txc = 1'b0; rx = 1'b0;
    check_eq("tx_count", 32'(ntx), 32'd2);
    check_eq("tx_code", 32'(got[0]), 32'(e0));
    check_eq("tx_data", 32'(got[1]), 32'(e1));
    check_eq("idle_after", 32'(ocupado), 32'd0);
    if (sens) check_eq("cmd_kept", 32'(sensorComando), 32'(cmd & 8'h07));
  endtask

  task automatic reset_mid();
    int n;
    send_pair(8'h03, 8'h05, 1, 1'b0);
    repeat (3) @(negedge clock);
    check_eq("mid_req", 32'(sensorSolicita), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_req_async", 32'(sensorSolicita), 32'd0);
    check_eq("rst_busy_async", 32'(ocupado), 32'd0);
    check_eq("rst_txbyte", 32'(txByte), 32'd0);
    @(negedge clock); reset = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      pronto = (i == 2); sdado = 8'h2A; txc = (i == 5);
      if (txInicio) n++;
      @(negedge clock);
    end
    pronto = 1'b0; txc = 1'b0;
    check_eq("rst_no_tx", 32'(n), 32'd0);
    check_eq("rst_idle", 32'(ocupado), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [7:0] c, a;
    repeat (2) @(negedge clock);
    check_eq("rst_busy", 32'(ocupado), 32'd0);
    check_eq("rst_req", 32'(sensorSolicita), 32'd0);
    check_eq("rst_cmd", {24'd0, 3'd0, sensorComando, 2'd0} | 32'(sensorEndereco), 32'd0);
    check_eq("rst_tx", {23'd0, txInicio, txByte}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    txn(8'h03, 8'h05, 8'h2A, 5, -1, 2, 1'b0);
    txn(8'h09, 8'h01, 8'h00, 3, -1, 0, 1'b0);
    txn(8'h01, 8'h20, 8'h00, 2, -1, 1, 1'b0);
    txn(8'h03, 8'h05, 8'h2A, 5, 7, 0, 1'b0);
    txn(8'h07, 8'h1F, 8'hC3, CT, -1, 0, 1'b0);
    txn(8'h00, 8'h04, 8'h5A, CT + 1, 3, 0, 1'b0);

    // Second byte never arrives.
    primeiro = 8'($urandom); rx = 1'b1;
    @(negedge clock); rx = 1'b0;
    n = 0;
    repeat (CT + 2) begin if (txInicio) n++; @(negedge clock); end
    check_eq("ag2_no_tx", 32'(n), 32'd0);
    check_eq("ag2_busy", 32'(ocupado), TEN ? 32'd0 : 32'd1);
    if (!TEN) txn(8'h02, 8'h06, 8'h11, 4, -1, 0, 1'b1);

    // Sensor never answers.
    if (TEN) txn(8'h00, 8'h04, 8'h00, -1, -1, 0, 1'b0);
    else begin
      send_pair(8'h00, 8'h04, 0, 1'b0);
      n = 0;
      repeat (1000) begin if (txInicio) n++; @(negedge clock); end
      check_eq("wait_no_tx", 32'(n), 32'd0);
      check_eq("wait_req", 32'(sensorSolicita), 32'd1);
      #2 reset = 1'b1;
      #1 check_eq("wait_rst_req", 32'(sensorSolicita), 32'd0);
      @(negedge clock); reset = 1'b0;
      @(negedge clock);
    end

    reset_mid();
    txn(8'h03, 8'h05, 8'h2A, 5, -1, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      c = ($urandom % 5 == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      a = ($urandom % 5 == 0) ? 8'($urandom) : 8'($urandom_range(0, NS - 1));
      txn(c, a, 8'($urandom),
          ($urandom % 6 == 0) ? int'($urandom_range(CT - 5, CT + 10)) : int'($urandom_range(1, 12)),
          ($urandom % 3 == 0) ? int'($urandom_range(0, 15)) : -1,
          int'($urandom_range(0, 3)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/controlador_comandos.md
CONTROLADOR_COMANDOS -- requirements
Module: controlador_comandos

Interface
REQ-001 SHALL have parameter NUM_SENSORES, default 32, number of addressable sensors (1..32).
REQ-002 SHALL have parameter CICLOS_TIMEOUT, default 2500000, timeout length in clock cycles (fits 22 bits).
REQ-003 SHALL have port clock  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port bitsEstaoRecebidos  input  1  one-cycle pulse from UART receiver per received byte.
REQ-006 SHALL have port primeiroByteCompleto  input  8  command byte from receiver.
REQ-007 SHALL have port segundoByteCompleto  input  8  address byte from receiver.
REQ-008 SHALL have port sensorSolicita  output  1  request level to sensor interface.
REQ-009 SHALL have port sensorComando  output  3  latched command to sensor.
REQ-010 SHALL have port sensorEndereco  output  5  latched address to sensor.
REQ-011 SHALL have port sensorPronto  input  1  one-cycle pulse, sensor data valid.
REQ-012 SHALL have port sensorDado  input  8  sensor data, valid with sensorPronto.
REQ-013 SHALL have port txInicio  output  1  one-cycle pulse starting one UART transmit.
REQ-014 SHALL have port txByte  output  8  byte to transmit, stable from txInicio until txConcluido.
REQ-015 SHALL have port txConcluido  input  1  one-cycle pulse, transmitter finished byte.
REQ-016 SHALL have port ocupado  output  1  high in every state except ESPERA.

Function
REQ-017 SHALL implement states ESPERA, AGUARDA_SEGUNDO, DECODIFICA, SOLICITA, AGUARDA_SENSOR, ENVIA1, ESPERA_TX1, ENVIA2, ESPERA_TX2.
REQ-018 ESPERA: bitsEstaoRecebidos pulse -> AGUARDA_SEGUNDO, timeout counter cleared.
REQ-019 AGUARDA_SEGUNDO: pulse -> latch primeiroByteCompleto and segundoByteCompleto same edge, -> DECODIFICA.
REQ-020 DECODIFICA (one cycle): command > 8'h07 -> codigo 8'hFF, dado = command byte; else address >= NUM_SENSORES -> codigo 8'hFE, dado = address byte; both -> ENVIA1; otherwise -> SOLICITA.
REQ-021 SOLICITA: sensorSolicita high, sensorComando = command[2:0], sensorEndereco = address[4:0], -> AGUARDA_SENSOR next cycle; sensorSolicita held high through AGUARDA_SENSOR.
REQ-022 AGUARDA_SENSOR: sensorPronto -> codigo = {5'b10000, command[2:0]}, dado = sensorDado, sensorSolicita low next cycle, -> ENVIA1.
REQ-023 ENVIA1: txInicio pulse one cycle with txByte = codigo, -> ESPERA_TX1; ESPERA_TX1 on txConcluido -> ENVIA2.
REQ-024 ENVIA2: txInicio pulse with txByte = dado, -> ESPERA_TX2; ESPERA_TX2 on txConcluido -> ESPERA.
REQ-025 bitsEstaoRecebidos pulses in any state after AGUARDA_SEGUNDO until return to ESPERA SHALL be ignored (dropped, no queueing).
REQ-026 sensorPronto outside AGUARDA_SENSOR and txConcluido outside ESPERA_TX1/ESPERA_TX2 SHALL be ignored.
REQ-027 sensorPronto coincident with timeout expiry SHALL win (data response, not error).
REQ-028 Latency: second bitsEstaoRecebidos pulse to sensorSolicita high = 2 cycles; to txInicio for error codes = 2 cycles.
REQ-029 txByte and latched command/address SHALL stay constant outside their load edges.

Reset
REQ-030 Reset SHALL force ESPERA and clear counter, latches, codigo, dado; outputs sensorSolicita 0, sensorComando 0, sensorEndereco 0, txInicio 0, txByte 8'h00, ocupado 0.
REQ-031 Reset asserted mid-transaction SHALL abort immediately (sensorSolicita and txInicio drop asynchronously); no response sent after release.

Configuration
REQ-032 Macro CONTROLADOR_TIMEOUT_EN defined: counter runs in AGUARDA_SEGUNDO and AGUARDA_SENSOR, cleared on state entry; reaching CICLOS_TIMEOUT-1 in AGUARDA_SEGUNDO -> ESPERA silently; in AGUARDA_SENSOR -> codigo 8'hFD, dado = address byte, sensorSolicita low, -> ENVIA1.
REQ-033 Macro undefined: no counter synthesized; both states wait indefinitely.

Verification
REQ-034 Bytes 8'h03, 8'h05, sensorPronto 5 cycles later with 8'h2A -> sensorComando 3, sensorEndereco 5, tx bytes 8'h83 then 8'h2A, ocupado low after second txConcluido.
REQ-035 Bytes 8'h09, 8'h01 -> no sensorSolicita; tx 8'hFF then 8'h09.
REQ-036 Bytes 8'h01, 8'h20 (NUM_SENSORES=32) -> tx 8'hFE then 8'h20.
REQ-037 TIMEOUT_EN, CICLOS_TIMEOUT=100, bytes 8'h00, 8'h04, no sensorPronto -> tx 8'hFD then 8'h04 after 100 cycles; without macro, no tx after 1000 cycles.
REQ-038 Extra bitsEstaoRecebidos during ESPERA_TX1 -> ignored, response 8'h83/8'h2A unchanged, returns to ESPERA.
REQ-039 Reset pulse during AGUARDA_SENSOR -> sensorSolicita 0 immediately, no txInicio afterwards, next valid pair served normally.
